load_ins_issuer: RTL and testbench

Scheduler-side transmitter for the LOAD instruction channel. It accepts field-level load requests, packs them into the 96-bit LOAD instruction word the decoder expects, and buffers them in a small FIFO. Buffered words are issued one at a time over the `ins_valid`/`ins_ready` handshake, and each completion is closed with an `ins_done`/`ins_done_ack` exchange. Back-to-back identical requests are dropped at the source, so the decoder never sees a repeated instruction.

---
 rtl/load_ins_pkg.sv | 44 ++++
 rtl/ins_fifo.sv | 57 +++++
 rtl/load_ins_issuer.sv | 136 +++++++++++++
 tb/tb_load_ins_issuer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_ins_pkg.sv
// Shared definitions for the LOAD instruction channel: field layout of the
// 96-bit instruction word, the packing helper and the issuer FSM states.
// The decoder imports the same offsets so both sides agree on the format.
package load_ins_pkg;

    localparam int LOAD_INS_LEN = 96;

    localparam int BANK_ADDR_LSB  = 0;
    localparam int BANK_ADDR_W    = 12;
    localparam int BANK_ID_LSB    = 12;
    localparam int BANK_ID_W      = 8;
    localparam int TOTAL_SIZE_LSB = 34;
    localparam int TOTAL_SIZE_W   = 16;
    localparam int LINE_SIZE_LSB  = 50;
    localparam int LINE_SIZE_W    = 12;
    localparam int DDR_ADDR_LSB   = 64;
    localparam int DDR_ADDR_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_ACK
    } issuer_state_e;

    // Build the instruction word; bits not owned by a field stay zero.
    function automatic logic [LOAD_INS_LEN-1:0] pack_load_ins(
        input logic [BANK_ID_W-1:0]    bank_id,
        input logic [BANK_ADDR_W-1:0]  bank_addr,
        input logic [LINE_SIZE_W-1:0]  line_size,
        input logic [TOTAL_SIZE_W-1:0] total_size,
        input logic [DDR_ADDR_W-1:0]   ddr_addr
    );
        logic [LOAD_INS_LEN-1:0] word;
        word = '0;
        word[BANK_ADDR_LSB  +: BANK_ADDR_W]  = bank_addr;
        word[BANK_ID_LSB    +: BANK_ID_W]    = bank_id;
        word[TOTAL_SIZE_LSB +: TOTAL_SIZE_W] = total_size;
        word[LINE_SIZE_LSB  +: LINE_SIZE_W]  = line_size;
        word[DDR_ADDR_LSB   +: DDR_ADDR_W]   = ddr_addr;
        return word;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO with full/empty/count. The head entry is always visible
// on head, so a pop and the use of its data happen in the same cycle.
module ins_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/load_ins_issuer.sv
// LOAD instruction transmitter: packs field-level requests, drops back-to-back
// duplicates, buffers words in a FIFO and issues them one at a time with a
// valid/ready handshake followed by a done/ack exchange.
module load_ins_issuer
    import load_ins_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_bank_id,
    input  logic [11:0]             req_bank_addr,
    input  logic [11:0]             req_line_size,
    input  logic [15:0]             req_total_size,
    input  logic [31:0]             req_ddr_addr,
    output logic [LOAD_INS_LEN-1:0] ins_data,
    output logic                    ins_valid,
    input  logic                    ins_ready,
    input  logic                    ins_done,
    output logic                    ins_done_ack,
    output logic                    dup_drop,
    output logic                    busy,
    output logic [CNT_W-1:0]        issued_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    issuer_state_e           state;
    issuer_state_e           state_nxt;
    logic [LOAD_INS_LEN-1:0] req_word;
    logic [LOAD_INS_LEN-1:0] last_word;
    logic                    last_valid;
    logic                    req_fire;
    logic                    is_dup;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [LOAD_INS_LEN-1:0] fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    cnt_inc;

    assign req_word  = pack_load_ins(req_bank_id, req_bank_addr, req_line_size,
                                     req_total_size, req_ddr_addr);
    // Full blocks new requests even in a cycle where the FSM pops.
    assign req_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign req_fire  = req_valid && req_ready;
    assign is_dup    = last_valid && (req_word == last_word);
    assign fifo_push = req_fire && !is_dup;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    ins_fifo #(
        .WIDTH (LOAD_INS_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (req_word),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Remember the last accepted word and flag a dropped duplicate one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_word  <= '0;
            last_valid <= 1'b0;
            dup_drop   <= 1'b0;
        end else begin
            dup_drop <= req_fire && is_dup && !fifo_full;
            if (req_fire) begin
                last_word  <= req_word;
                last_valid <= 1'b1;
            end
        end
    end

    // Issue FSM next-state and handshake outputs.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_nxt    = state;
        fifo_pop     = 1'b0;
        cnt_inc      = 1'b0;
        ins_valid    = 1'b0;
        ins_done_ack = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ins_valid = 1'b1;
                if (ins_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (ins_done) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                ins_done_ack = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Instruction register: loaded only on pop, so it holds steady through ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ins_data <= '0;
        else if (fifo_pop) ins_data <= fifo_head;
    end

    // Completed-handshake counter, wrapping at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         issued_cnt <= '0;
        else if (cnt_inc) issued_cnt <= issued_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_load_ins_issuer.sv
// Directed bench for load_ins_issuer. A second instance with a 2-bit counter
// sees the same stimulus to exercise counter wrap.
module tb_load_ins_issuer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_bank_id;
    logic [11:0] req_bank_addr;
    logic [11:0] req_line_size;
    logic [15:0] req_total_size;
    logic [31:0] req_ddr_addr;
    logic        ins_ready;
    logic        ins_done;

    logic        req_ready;
    logic [95:0] ins_data;
    logic        ins_valid;
    logic        ins_done_ack;
    logic        dup_drop;
    logic        busy;
    logic [15:0] issued_cnt;

    logic        d2_req_ready;
    logic [95:0] d2_ins_data;
    logic        d2_ins_valid;
    logic        d2_ins_done_ack;
    logic        d2_dup_drop;
    logic        d2_busy;
    logic [1:0]  d2_issued_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    load_ins_issuer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_bank_id(req_bank_id), .req_bank_addr(req_bank_addr),
        .req_line_size(req_line_size), .req_total_size(req_total_size),
        .req_ddr_addr(req_ddr_addr), .ins_data(ins_data), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_done(ins_done), .ins_done_ack(ins_done_ack),
        .dup_drop(dup_drop), .busy(busy), .issued_cnt(issued_cnt)
    );

    load_ins_issuer #(.FIFO_DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d2_req_ready),
        .req_bank_id(req_bank_id), .req_bank_addr(req_bank_addr),
        .req_line_size(req_line_size), .req_total_size(req_total_size),
        .req_ddr_addr(req_ddr_addr), .ins_data(d2_ins_data), .ins_valid(d2_ins_valid),
        .ins_ready(ins_ready), .ins_done(ins_done), .ins_done_ack(d2_ins_done_ack),
        .dup_drop(d2_dup_drop), .busy(d2_busy), .issued_cnt(d2_issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted.
    task automatic send(input logic [7:0] id, input logic [11:0] addr, input logic [11:0] line,
                        input logic [15:0] total, input logic [31:0] ddr);
        int n = 0;
        req_valid      = 1'b1;
        req_bank_id    = id;
        req_bank_addr  = addr;
        req_line_size  = line;
        req_total_size = total;
        req_ddr_addr   = ddr;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_timeout", 96'd0, 96'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Wait for the instruction, check it, and complete the valid/ready handshake.
    task automatic issue_only(input string tag, input logic [95:0] exp);
        int n = 0;
        while (!ins_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, ins_valid, 96'd1);
        check({tag, "_data"}, ins_data, exp);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
    endtask

    // Full issue: handshake, then done/ack exchange, ending back in IDLE.
    task automatic complete_one(input string tag, input logic [95:0] exp);
        issue_only(tag, exp);
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        check({tag, "_ack"}, ins_done_ack, 96'd1);
        tick();
    endtask

    logic [95:0] d_exp [5];
    logic [95:0] w_exp [4];

    initial begin
        d_exp[0] = 96'hD000_0000_0000_0000_0002_0100;
        d_exp[1] = 96'hD000_0001_0000_0000_0002_1101;
        d_exp[2] = 96'hD000_0002_0000_0000_0002_2102;
        d_exp[3] = 96'hD000_0003_0000_0000_0002_3103;
        d_exp[4] = 96'hD000_0004_0000_0000_0002_4104;
        w_exp[0] = 96'hE000_0001_0000_0000_0004_1301;
        w_exp[1] = 96'hE000_0002_0000_0000_0004_2302;
        w_exp[2] = 96'hE000_0003_0000_0000_0004_3303;
        w_exp[3] = 96'hE000_0004_0000_0000_0004_4304;

        rst            = 1'b0;
        req_valid      = 1'b0;
        req_bank_id    = '0;
        req_bank_addr  = '0;
        req_line_size  = '0;
        req_total_size = '0;
        req_ddr_addr   = '0;
        ins_ready      = 1'b0;
        ins_done       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset values
        check("rst_ins_valid", ins_valid, 96'd0);
        check("rst_ins_data", ins_data, 96'd0);
        check("rst_ack", ins_done_ack, 96'd0);
        check("rst_dup", dup_drop, 96'd0);
        check("rst_busy", busy, 96'd0);
        check("rst_cnt", issued_cnt, 96'd0);
        check("rst_req_ready", req_ready, 96'd1);

        // Single request: 2-cycle latency, data held while ready is low
        send(8'h05, 12'h123, 12'h040, 16'h0400, 32'h8000_0000);
        check("single_lat1_valid", ins_valid, 96'd0);
        check("single_busy", busy, 96'd1);
        tick();
        check("single_lat2_valid", ins_valid, 96'd1);
        check("single_data", ins_data, 96'h8000_0000_0100_1000_0000_5123);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_hold_valid", ins_valid, 96'd1);
            check("single_hold_data", ins_data, 96'h8000_0000_0100_1000_0000_5123);
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        check("single_post_valid", ins_valid, 96'd0);
        check("single_cnt", issued_cnt, 96'd1);
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        check("single_ack", ins_done_ack, 96'd1);
        tick();
        check("single_ack_one_cycle", ins_done_ack, 96'd0);
        check("single_idle_busy", busy, 96'd0);

        // Duplicate suppression
        send(8'h11, 12'h001, 12'h000, 16'h0000, 32'h0000_1000);
        check("dup_first_no_drop", dup_drop, 96'd0);
        send(8'h11, 12'h001, 12'h000, 16'h0000, 32'h0000_1000);
        check("dup_drop_pulse", dup_drop, 96'd1);
        tick();
        check("dup_drop_cleared", dup_drop, 96'd0);
        send(8'h11, 12'h001, 12'h000, 16'h0000, 32'h0000_2000);
        check("dup_third_no_drop", dup_drop, 96'd0);
        complete_one("dup_b", 96'h0000_1000_0000_0000_0001_1001);
        complete_one("dup_c", 96'h0000_2000_0000_0000_0001_1001);
        check("dup_busy", busy, 96'd0);
        check("dup_cnt", issued_cnt, 96'd3);

        // All-ones fields: zero gaps in the layout stay zero
        send(8'hFF, 12'hFFF, 12'hFFF, 16'hFFFF, 32'hFFFF_FFFF);
        issue_wait: begin
            int n = 0;
            while (!ins_valid && n < 50) begin
                tick();
                n++;
            end
        end
        check("ones_data", ins_data, 96'hFFFF_FFFF_3FFF_FFFC_000F_FFFF);

        // ins_done during ISSUE is ignored
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        check("early_done_no_ack", ins_done_ack, 96'd0);
        check("early_done_valid", ins_valid, 96'd1);
        tick();
        check("early_done_no_ack2", ins_done_ack, 96'd0);
        check("early_done_still_issue", ins_valid, 96'd1);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        check("ones_cnt", issued_cnt, 96'd4);

        // Fill FIFO while the decoder holds the previous instruction
        for (int i = 0; i < 4; i++)
            send(8'h20 + 8'(i), 12'h100 + 12'(i), 12'h000, 16'h0000, 32'hD000_0000 + 32'(i));
        check("full_req_ready", req_ready, 96'd0);
        req_valid      = 1'b1;
        req_bank_id    = 8'h24;
        req_bank_addr  = 12'h104;
        req_line_size  = 12'h000;
        req_total_size = 16'h0000;
        req_ddr_addr   = 32'hD000_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_blocked", req_ready, 96'd0);
        end
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        check("full_prev_ack", ins_done_ack, 96'd1);
        tick();
        check("full_still_blocked", req_ready, 96'd0);
        tick();
        check("full_pop_ready", req_ready, 96'd1);
        check("full_pop_data", ins_data, d_exp[0]);
        tick();
        req_valid = 1'b0;
        check("full_fifth_refill", req_ready, 96'd0);
        for (int i = 0; i < 5; i++)
            complete_one($sformatf("drain%0d", i), d_exp[i]);
        check("drain_busy", busy, 96'd0);
        check("drain_cnt", issued_cnt, 96'd9);
        check("drain_cnt_w2", d2_issued_cnt, 96'd1);

        // Reset while in WAIT_DONE with two queued entries
        send(8'h30, 12'h200, 12'h000, 16'h0000, 32'h0000_0001);
        issue_only("rst_r1", 96'h0000_0001_0000_0000_0003_0200);
        send(8'h31, 12'h201, 12'h000, 16'h0000, 32'h0000_0002);
        send(8'h32, 12'h202, 12'h000, 16'h0000, 32'h0000_0003);
        check("pre_rst_busy", busy, 96'd1);
        check("pre_rst_req_ready", req_ready, 96'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", ins_valid, 96'd0);
        check("mid_rst_busy", busy, 96'd0);
        check("mid_rst_cnt", issued_cnt, 96'd0);
        check("mid_rst_ack", ins_done_ack, 96'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_valid", ins_valid, 96'd0);
        check("post_rst_busy", busy, 96'd0);
        send(8'h32, 12'h202, 12'h000, 16'h0000, 32'h0000_0003);
        check("post_rst_no_dedup", dup_drop, 96'd0);
        complete_one("post_rst_r3", 96'h0000_0003_0000_0000_0003_2202);

        // Counter wrap on the 2-bit instance
        for (int i = 0; i < 4; i++)
            send(8'h41 + 8'(i), 12'h301 + 12'(i), 12'h000, 16'h0000, 32'hE000_0001 + 32'(i));
        for (int i = 0; i < 4; i++)
            complete_one($sformatf("wrap%0d", i), w_exp[i]);
        check("wrap_cnt16", issued_cnt, 96'd5);
        check("wrap_cnt2", d2_issued_cnt, 96'd1);
        check("wrap_busy", busy, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
